fec_chain_controller: RTL and testbench
=======================================

FEC_CHAIN_CONTROLLER -- requirements
Module: fec_chain_controller

Interface
REQ-001 SHALL have parameter BLOCK_LEN, default 8, meaning buffer words per frame (legal range 2..255).
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of cycles spent waiting for a stage ack.
REQ-003 SHALL derive CNT_W = $clog2(BLOCK_LEN+1) and TMO_W = $clog2(TIMEOUT+1) internally, not as user parameters.
REQ-004 clk  input  1  sole clock; all logic rising-edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 en  input  1  block enable; low aborts any frame.
REQ-007 req  input  1  frame start request.
REQ-008 mode  input  1  0 = TX (encoder then modulator), 1 = RX (demodulator then decoder).
REQ-009 buff_empty, buff_full  input  1 each  frame buffer status.
REQ-010 ack_encoder, ack_decoder, ack_modulator, ack_demodulator  input  1 each  stage done.
REQ-011 req_encoder, req_decoder, req_modulator, req_demodulator  output  1 each  stage request.
REQ-012 en_encoder, en_decoder, en_modulator, en_demodulator  output  1 each  stage enable.
REQ-013 wr_en_buff, rd_en_buff  output  1 each  buffer write and read strobes.
REQ-014 ack  output  1  one-cycle frame-complete pulse.
REQ-015 busy  output  1  high in every state except IDLE and ERR.
REQ-016 err  output  1  timeout flag.
REQ-017 words_done  output  CNT_W  current LOAD or READ word count.

Function
REQ-018 SHALL implement the FSM states IDLE, LOAD, READ, WAIT1, WAIT2, DONE and ERR; all outputs SHALL be registered.
REQ-019 IDLE->LOAD when en&&req; mode SHALL be latched on that cycle and held for the whole frame.
REQ-020 LOAD: wr_en_buff=1 on cycles where !buff_full; words_done increments per write; after BLOCK_LEN writes -> READ with words_done cleared.
REQ-021 READ: the first stage's en is high and rd_en_buff=1 on cycles where !buff_empty; after BLOCK_LEN reads -> WAIT1.
REQ-022 First stage is encoder for TX and demodulator for RX; second stage is modulator for TX and decoder for RX.
REQ-023 WAIT1: req and en of the first stage high; req SHALL stay high until the corresponding ack is sampled high; the next cycle is WAIT2 with that req low.
REQ-024 WAIT2: same handshake on the second stage; on its ack -> DONE.
REQ-025 DONE: ack=1 for exactly one cycle, then -> IDLE.
REQ-026 Acks from stages not currently requested SHALL be ignored; an ack asserted in the same cycle req rises SHALL be honoured.
REQ-027 Watchdog SHALL clear on entry to WAIT1 and WAIT2 and increment each waiting cycle; reaching TIMEOUT -> ERR with err=1 and all req/en/strobe outputs low.
REQ-028 ERR -> IDLE only when req is low; err SHALL clear on leaving ERR.
REQ-029 en low in any state SHALL force IDLE the next cycle with no ack pulse; err SHALL be preserved if already set.
REQ-030 req held high after DONE SHALL NOT restart a frame until req is seen low for at least one cycle.
REQ-031 Buffer stall (full in LOAD, empty in READ) SHALL hold the state and counter without timing out.

Reset
REQ-032 With rst_n low at a clock edge: state=IDLE; all req_*, en_*, wr_en_buff, rd_en_buff, ack, busy and err = 0; words_done, watchdog and latched mode = 0.
REQ-033 Reset mid-frame SHALL abandon the frame without an ack pulse.

Structure
REQ-034 encoder_fec_pck SHALL hold the state enum, the mode enum (MODE_TX, MODE_RX) and the default BLOCK_LEN/TIMEOUT constants.
REQ-035 The watchdog SHALL be a sub-module fec_watchdog (clear, tick, expired; parameter TIMEOUT).

Verification
REQ-036 TX, BLOCK_LEN=4, no stalls, acks returned 1 cycle after req: 4 wr, 4 rd, req_encoder then req_modulator; ack pulse exactly 12 cycles after req accepted.
REQ-037 RX with buff_empty toggled in READ: rd_en_buff only when !buff_empty; req_demodulator precedes req_decoder; ack pulse once.
REQ-038 TIMEOUT=10, ack_modulator never returned: err=1 on the 11th WAIT2 cycle with all req low; ERR held until req is dropped.
REQ-039 en dropped during WAIT1: IDLE next cycle, req_encoder low, no ack pulse; a new frame then completes normally.
REQ-040 rst_n low during LOAD at words_done=2: every output equals its reset value next cycle; spurious ack_decoder in TX mode has no effect.

Source files
------------

// File: rtl/encoder_fec_pck.sv
// encoder_fec_pck: shared state/mode types and default sizing for the FEC chain controller
package encoder_fec_pck;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_READ, S_WAIT1, S_WAIT2, S_DONE, S_ERR} state_t;
  typedef enum logic {MODE_TX = 1'b0, MODE_RX = 1'b1} mode_t;
  localparam int DEF_BLOCK_LEN = 8;
  localparam int DEF_TIMEOUT = 255;
endpackage

// File: rtl/fec_watchdog.sv
// fec_watchdog: counts stalled handshake cycles; expired fires on the tick that reaches TIMEOUT
module fec_watchdog
  import encoder_fec_pck::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic tick,
  output logic expired
);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clear ? '0 : tick ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= !rst_n ? '0 : cnt_d;
  assign expired = tick && (cnt_q == TMO_W'(TIMEOUT - 1));
endmodule

// File: rtl/fec_chain_controller.sv
// fec_chain_controller: per frame, fills and drains the buffer, then handshakes two FEC stages in order
module fec_chain_controller
  import encoder_fec_pck::*;
#(
  parameter int BLOCK_LEN = DEF_BLOCK_LEN,
  parameter int TIMEOUT = DEF_TIMEOUT,
  localparam int CNT_W = $clog2(BLOCK_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             req,
  input  logic             mode,
  input  logic             buff_empty,
  input  logic             buff_full,
  input  logic             ack_encoder,
  input  logic             ack_decoder,
  input  logic             ack_modulator,
  input  logic             ack_demodulator,
  output logic             req_encoder,
  output logic             req_decoder,
  output logic             req_modulator,
  output logic             req_demodulator,
  output logic             en_encoder,
  output logic             en_decoder,
  output logic             en_modulator,
  output logic             en_demodulator,
  output logic             wr_en_buff,
  output logic             rd_en_buff,
  output logic             ack,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] words_done
);
  state_t state_q, state_d;
  mode_t mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic block_q, block_d, wr_q, wr_d, rd_q, rd_d, ack_q, ack_d, busy_q, busy_d, err_q, err_d;
  logic [3:0] req_q, req_d, en_q, en_d;
  logic ack_first, ack_second, last_word, tick, expired, rx, first_en;
  assign ack_first = mode_q == MODE_RX ? ack_demodulator : ack_encoder;
  assign ack_second = mode_q == MODE_RX ? ack_decoder : ack_modulator;
  assign last_word = cnt_q == CNT_W'(BLOCK_LEN - 1);
  assign tick = (state_q == S_WAIT1 && !ack_first) || (state_q == S_WAIT2 && !ack_second);
  fec_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk(clk),
    .rst_n(rst_n),
    .clear(state_d != state_q),
    .tick(tick),
    .expired(expired)
  );
  // block_q keeps a req held across DONE from launching another frame until it is seen low
  always_comb begin
    state_d = state_q;
    mode_d = mode_q;
    cnt_d = cnt_q;
    block_d = block_q && req;
    wr_d = 1'b0;
    rd_d = 1'b0;
    case (state_q)
      S_IDLE: if (req && !block_q) begin
        state_d = S_LOAD;
        mode_d = mode_t'(mode);
      end
      S_LOAD: if (!buff_full) begin
        wr_d = 1'b1;
        cnt_d = last_word ? '0 : cnt_q + 1'b1;
        state_d = last_word ? S_READ : S_LOAD;
      end
      S_READ: if (!buff_empty) begin
        rd_d = 1'b1;
        cnt_d = last_word ? '0 : cnt_q + 1'b1;
        state_d = last_word ? S_WAIT1 : S_READ;
      end
      S_WAIT1: state_d = ack_first ? S_WAIT2 : expired ? S_ERR : S_WAIT1;
      S_WAIT2: state_d = ack_second ? S_DONE : expired ? S_ERR : S_WAIT2;
      S_DONE: begin
        state_d = S_IDLE;
        block_d = 1'b1;
      end
      S_ERR: state_d = req ? S_ERR : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (!en) begin
      state_d = S_IDLE;
      mode_d = mode_q;
      cnt_d = '0;
      wr_d = 1'b0;
      rd_d = 1'b0;
    end
    rx = mode_d == MODE_RX;
    first_en = state_d == S_READ || state_d == S_WAIT1;
    busy_d = state_d != S_IDLE && state_d != S_ERR;
    ack_d = state_d == S_DONE;
    err_d = state_d == S_ERR || (err_q && !en);
    req_d = rx ? {state_d == S_WAIT1, state_d == S_WAIT2, 2'b00} : {2'b00, state_d == S_WAIT2, state_d == S_WAIT1};
    en_d = rx ? {first_en, state_d == S_WAIT2, 2'b00} : {2'b00, state_d == S_WAIT2, first_en};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q <= MODE_TX;
      cnt_q <= '0;
      block_q <= 1'b0;
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      ack_q <= 1'b0;
      busy_q <= 1'b0;
      err_q <= 1'b0;
      req_q <= '0;
      en_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      cnt_q <= cnt_d;
      block_q <= block_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      ack_q <= ack_d;
      busy_q <= busy_d;
      err_q <= err_d;
      req_q <= req_d;
      en_q <= en_d;
    end
  end
  // stage vectors are ordered {demodulator, decoder, modulator, encoder}
  assign {req_demodulator, req_decoder, req_modulator, req_encoder} = req_q;
  assign {en_demodulator, en_decoder, en_modulator, en_encoder} = en_q;
  assign wr_en_buff = wr_q;
  assign rd_en_buff = rd_q;
  assign ack = ack_q;
  assign busy = busy_q;
  assign err = err_q;
  assign words_done = cnt_q;
endmodule

// File: tb/tb_fec_chain_controller.sv
// tb_fec_chain_controller: randomized frames checked against a per-frame schedule built from the frame rules
module tb_fec_chain_controller;
  localparam int BL = 4;
  localparam int TMO = 10;
  logic clk = 1'b0;
  logic rst_n, en, req, mode, buff_empty, buff_full;
  logic ack_encoder, ack_decoder, ack_modulator, ack_demodulator;
  logic req_encoder, req_decoder, req_modulator, req_demodulator;
  logic en_encoder, en_decoder, en_modulator, en_demodulator;
  logic wr_en_buff, rd_en_buff, ack, busy, err;
  logic [2:0] words_done;
  int total = 0;
  int bad = 0;
  int lat;
  bit x_wr[256], x_rd[256], x_ack[256], x_busy[256], x_err[256];
  bit sf[256], se[256], a1[256], a2[256];
  logic [3:0] x_req[256], x_en[256];
  int x_wd[256];

  always #5 clk = ~clk;

  fec_chain_controller #(.BLOCK_LEN(BL), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .mode(mode),
    .buff_empty(buff_empty), .buff_full(buff_full),
    .ack_encoder(ack_encoder), .ack_decoder(ack_decoder),
    .ack_modulator(ack_modulator), .ack_demodulator(ack_demodulator),
    .req_encoder(req_encoder), .req_decoder(req_decoder),
    .req_modulator(req_modulator), .req_demodulator(req_demodulator),
    .en_encoder(en_encoder), .en_decoder(en_decoder),
    .en_modulator(en_modulator), .en_demodulator(en_demodulator),
    .wr_en_buff(wr_en_buff), .rd_en_buff(rd_en_buff),
    .ack(ack), .busy(busy), .err(err), .words_done(words_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] reqv();
    return {req_demodulator, req_decoder, req_modulator, req_encoder};
  endfunction

  function automatic logic [3:0] env();
    return {en_demodulator, en_decoder, en_modulator, en_encoder};
  endfunction

  function automatic logic [12:0] outs();
    return {reqv(), env(), wr_en_buff, rd_en_buff, ack, busy, err};
  endfunction

  task automatic quiet();
    buff_full = 0;
    buff_empty = 0;
    ack_encoder = 0;
    ack_decoder = 0;
    ack_modulator = 0;
    ack_demodulator = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Builds the expected per-cycle outputs of one frame, then drives it and compares.
  // Index k is the k-th cycle after the edge that accepts the request.
  // sp: 0 no stalls, 1 random stalls, 2 buff_empty toggling every cycle.
  // d1/d2: cycles from a stage req rising to its ack; >= TMO means never.
  task automatic run_frame(input bit rx, input int d1, input int d2, input int sp, input int hold,
                           output int seen);
    int t, n, len, tend, tlast;
    bit stall, failed;
    logic [3:0] first, second;
    first = rx ? 4'b1000 : 4'b0001;
    second = rx ? 4'b0100 : 4'b0010;
    for (int i = 0; i < 256; i++) begin
      x_wr[i] = 0; x_rd[i] = 0; x_ack[i] = 0; x_busy[i] = 0; x_err[i] = 0;
      x_req[i] = 0; x_en[i] = 0; x_wd[i] = 0; a1[i] = 0; a2[i] = 0;
      sf[i] = (sp == 1) && (i < 100) && ($urandom_range(0, 2) == 0);
      se[i] = (sp == 1) ? ((i < 100) && ($urandom_range(0, 2) == 0)) : (sp == 2) ? i[0] : 1'b0;
    end
    x_busy[0] = 1;
    t = 0;
    n = 0;
    while (n < BL) begin
      stall = sf[t];
      t++;
      if (!stall) begin n++; x_wr[t] = 1; end
      x_wd[t] = (n == BL) ? 0 : n;
      x_busy[t] = 1;
      x_en[t] = (n == BL) ? first : 4'b0;
    end
    n = 0;
    while (n < BL) begin
      stall = se[t];
      t++;
      if (!stall) begin n++; x_rd[t] = 1; end
      x_wd[t] = (n == BL) ? 0 : n;
      x_busy[t] = 1;
      x_en[t] = first;
    end
    len = (d1 < TMO) ? d1 + 1 : TMO;
    for (int j = 0; j < len; j++) begin x_req[t+j] = first; x_en[t+j] = first; x_busy[t+j] = 1; end
    if (d1 < TMO) a1[t+d1] = 1;
    t += len;
    failed = d1 >= TMO;
    if (!failed) begin
      len = (d2 < TMO) ? d2 + 1 : TMO;
      for (int j = 0; j < len; j++) begin x_req[t+j] = second; x_en[t+j] = second; x_busy[t+j] = 1; end
      if (d2 < TMO) a2[t+d2] = 1;
      t += len;
      failed = d2 >= TMO;
    end
    if (failed) for (int j = 0; j <= hold; j++) x_err[t+j] = 1;
    else begin x_ack[t] = 1; x_busy[t] = 1; end
    tend = t;
    tlast = t + hold + 2;
    seen = -1;
    req = 1;
    mode = rx;
    for (int k = 0; k <= tlast; k++) begin
      tick();
      check($sformatf("wr@%0d", k), wr_en_buff, x_wr[k]);
      check($sformatf("rd@%0d", k), rd_en_buff, x_rd[k]);
      check($sformatf("words@%0d", k), words_done, x_wd[k]);
      check($sformatf("req@%0d", k), reqv(), x_req[k]);
      check($sformatf("en@%0d", k), env(), x_en[k]);
      check($sformatf("ack@%0d", k), ack, x_ack[k]);
      check($sformatf("busy@%0d", k), busy, x_busy[k]);
      check($sformatf("err@%0d", k), err, x_err[k]);
      if (ack === 1'b1 && seen < 0) seen = k;
      buff_full = sf[k];
      buff_empty = se[k];
      mode = 1'($urandom_range(0, 1));
      req = k < tend + hold;
      if (rx) begin
        ack_demodulator = a1[k]; ack_decoder = a2[k];
        ack_encoder = 1'($urandom_range(0, 1)); ack_modulator = 1'($urandom_range(0, 1));
      end else begin
        ack_encoder = a1[k]; ack_modulator = a2[k];
        ack_decoder = 1'($urandom_range(0, 1)); ack_demodulator = 1'($urandom_range(0, 1));
      end
    end
    quiet();
  endtask

  function automatic int pick_delay();
    return ($urandom_range(0, 7) == 0) ? int'($urandom_range(9, 13)) : int'($urandom_range(0, 3));
  endfunction

  initial begin
    rst_n = 0; en = 1; req = 1; mode = 1;
    quiet();
    repeat (2) tick();
    check("rst_outs", outs(), 0);
    check("rst_words", words_done, 0);
    rst_n = 1; req = 0; mode = 0;
    tick();
    check("idle_busy", busy, 0);
    run_frame(0, 1, 1, 0, 2, lat);
    check("tx_ack_latency", lat, 12);
    run_frame(1, 2, 0, 2, 1, lat);
    check("rx_ack_seen", lat > 0, 1);
    run_frame(0, 1, 50, 0, 3, lat);
    run_frame(1, 9, 9, 0, 1, lat);
    req = 1; mode = 0;
    for (int k = 0; k < 40 && req_encoder !== 1'b1; k++) tick();
    check("w1_reached", req_encoder, 1);
    en = 0; req = 0;
    tick();
    check("abort_busy", busy, 0);
    check("abort_req_enc", req_encoder, 0);
    check("abort_ack", ack, 0);
    en = 1;
    repeat (2) begin
      tick();
      check("abort_quiet", {ack, busy}, 0);
    end
    run_frame(0, 0, 2, 1, 1, lat);
    req = 1; mode = 1;
    for (int k = 0; k < 60 && err !== 1'b1; k++) tick();
    check("tmo_err", err, 1);
    check("tmo_reqs", reqv(), 0);
    en = 0;
    tick();
    check("enlow_err_kept", err, 1);
    check("enlow_busy", busy, 0);
    en = 1; req = 0;
    tick();
    check("err_cleared", err, 0);
    req = 1; mode = 0;
    for (int k = 0; k < 20 && words_done !== 3'd2; k++) tick();
    check("load_wd2", words_done, 2);
    rst_n = 0; ack_decoder = 1;
    tick();
    check("midrst_outs", outs(), 0);
    check("midrst_words", words_done, 0);
    rst_n = 1; req = 0;
    repeat (3) begin
      tick();
      check("post_rst_idle", {ack, busy, reqv()}, 0);
    end
    ack_decoder = 0;
    for (int f = 0; f < 16; f++)
      run_frame(1'($urandom_range(0, 1)), pick_delay(), pick_delay(), int'($urandom_range(0, 2)),
                int'($urandom_range(1, 3)), lat);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
